// File: rtl/ft_fifo_lat.sv
// Flow-through adapter: turns a RAM FIFO with RAM_LAT-clock read latency into a
// zero-latency head/peek interface using a credit-tracked skid buffer.
module ft_fifo_lat #(
  parameter int FIFO_WIDTH = 32,
  parameter int RAM_LAT    = 2,
  parameter bit LESS_RST   = 1'b0,
  localparam int SKID      = RAM_LAT + 1,
  localparam int CW        = $clog2(SKID + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sync_rst_n,
  input  logic                  ram_fifo_empty,
  input  logic [FIFO_WIDTH-1:0] ram_fifo_data,
  input  logic                  ft_pop,
  output logic                  ram_pop,
  output logic                  ft_valid,
  output logic [FIFO_WIDTH-1:0] ft_data,
  output logic                  ft_valid2,
  output logic [FIFO_WIDTH-1:0] ft_data2,
  output logic [CW-1:0]         ft_cnt
);

  localparam logic [CW-1:0] SKID_C = CW'(SKID);

  if (RAM_LAT < 1 || RAM_LAT > 4) begin : g_bad_lat
    $error("ft_fifo_lat: RAM_LAT must be in 1..4");
  end

  logic [CW-1:0]         credit;
  logic [CW-1:0]         credit_nxt;
  logic [RAM_LAT-1:0]    pipe;
  logic [RAM_LAT-1:0]    pipe_nxt;
  logic                  ret;
  logic                  qual_pop;
  logic                  placed;
  logic [SKID-1:0]       valid;
  logic [SKID-1:0]       valid_nxt;
  logic [FIFO_WIDTH-1:0] data_q   [SKID];
  logic [FIFO_WIDTH-1:0] data_nxt [SKID];

  assign qual_pop  = ft_pop & valid[0];
  assign ram_pop   = !ram_fifo_empty & sync_rst_n & ((credit < SKID_C) | qual_pop);
  assign ret       = pipe[RAM_LAT-1];
  assign ft_valid  = valid[0];
  assign ft_valid2 = valid[1];
  assign ft_data   = data_q[0];
  assign ft_data2  = data_q[1];

  // Each bit of the pipe marks a read whose data is still travelling through the RAM.
  if (RAM_LAT == 1) begin : g_pipe1
    assign pipe_nxt = ram_pop;
  end else begin : g_pipen
    assign pipe_nxt = {pipe[RAM_LAT-2:0], ram_pop};
  end

  always_comb begin
    credit_nxt = credit;
    if (ram_pop && !qual_pop)
      credit_nxt = credit + 1'b1;
    else if (qual_pop && !ram_pop)
      credit_nxt = credit - 1'b1;
  end

  // Pop shifts the compacted skid down first, so a same-cycle return lands behind it.
  always_comb begin
    valid_nxt = valid;
    data_nxt  = data_q;
    placed    = 1'b0;
    if (qual_pop) begin
      for (int i = 0; i < SKID - 1; i++) begin
        valid_nxt[i] = valid[i+1];
        data_nxt[i]  = data_q[i+1];
      end
      valid_nxt[SKID-1] = 1'b0;
    end
    if (ret) begin
      for (int i = 0; i < SKID; i++) begin
        if (!placed && !valid_nxt[i]) begin
          valid_nxt[i] = 1'b1;
          data_nxt[i]  = ram_fifo_data;
          placed       = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ft_cnt = '0;
    for (int i = 0; i < SKID; i++)
      ft_cnt = ft_cnt + CW'(valid[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit <= '0;
      pipe   <= '0;
      valid  <= '0;
    end else if (!sync_rst_n) begin
      credit <= '0;
      pipe   <= '0;
      valid  <= '0;
    end else begin
      credit <= credit_nxt;
      pipe   <= pipe_nxt;
      valid  <= valid_nxt;
    end
  end

  // Payload flops may skip reset: valid bits alone decide what is visible.
  if (LESS_RST) begin : g_data_norst
    always_ff @(posedge clk) begin
      data_q <= data_nxt;
    end
  end else begin : g_data_rst
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < SKID; i++) data_q[i] <= '0;
      end else if (!sync_rst_n) begin
        for (int i = 0; i < SKID; i++) data_q[i] <= '0;
      end else begin
        data_q <= data_nxt;
      end
    end
  end

  a_credit_ovf: assert property (@(posedge clk) disable iff (!rst_n)
    credit <= SKID_C)
    else $error("design_error: credit overflow");

  a_skid_ovf: assert property (@(posedge clk) disable iff (!rst_n)
    !(sync_rst_n && ret && !qual_pop && (&valid)))
    else $error("design_error: skid write with no free entry");

  a_ret_nocredit: assert property (@(posedge clk) disable iff (!rst_n)
    !(sync_rst_n && ret && credit == '0))
    else $error("design_error: return with zero credit");

endmodule

// File: tb/tb_ft_fifo_lat.sv
// Bench for ft_fifo_lat: three configurations checked one at a time against a
// queue-based model of the RAM, the reads in flight and the visible skid contents.
module tb_ft_fifo_lat;

  logic        clk;
  logic        rst_n;
  logic        sync_rst_n;
  logic        emp   [3];
  logic        popi  [3];
  logic [31:0] rdata [3];
  logic        rpop  [3];
  logic        fv    [3];
  logic        fv2   [3];
  logic [31:0] fd    [3];
  logic [31:0] fd2   [3];
  logic [2:0]  cnt3  [3];
  logic [1:0]  cnt0;
  logic [1:0]  cnt1;
  logic [2:0]  cnt2;

  int total;
  int bad;

  int cur;
  int lat;
  int skid;
  bit lessrst;
  int cyc;
  logic [31:0] ramq   [$];
  logic [31:0] avail  [$];
  logic [31:0] infl_w [$];
  int          infl_t [$];
  logic [31:0] slot   [8];

  ft_fifo_lat #(.FIFO_WIDTH(32), .RAM_LAT(2), .LESS_RST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .sync_rst_n(sync_rst_n),
    .ram_fifo_empty(emp[0]), .ram_fifo_data(rdata[0]), .ft_pop(popi[0]),
    .ram_pop(rpop[0]), .ft_valid(fv[0]), .ft_data(fd[0]),
    .ft_valid2(fv2[0]), .ft_data2(fd2[0]), .ft_cnt(cnt0));

  ft_fifo_lat #(.FIFO_WIDTH(32), .RAM_LAT(1), .LESS_RST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sync_rst_n(sync_rst_n),
    .ram_fifo_empty(emp[1]), .ram_fifo_data(rdata[1]), .ft_pop(popi[1]),
    .ram_pop(rpop[1]), .ft_valid(fv[1]), .ft_data(fd[1]),
    .ft_valid2(fv2[1]), .ft_data2(fd2[1]), .ft_cnt(cnt1));

  ft_fifo_lat #(.FIFO_WIDTH(32), .RAM_LAT(4), .LESS_RST(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .sync_rst_n(sync_rst_n),
    .ram_fifo_empty(emp[2]), .ram_fifo_data(rdata[2]), .ft_pop(popi[2]),
    .ram_pop(rpop[2]), .ft_valid(fv[2]), .ft_data(fd[2]),
    .ft_valid2(fv2[2]), .ft_data2(fd2[2]), .ft_cnt(cnt2));

  assign cnt3[0] = {1'b0, cnt0};
  assign cnt3[1] = {1'b0, cnt1};
  assign cnt3[2] = cnt2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s cfg=%0d cyc=%0d got=%h exp=%h", tag, cur, cyc, got, exp);
    end
  endtask

  task automatic pushWords(input int n);
    for (int i = 0; i < n; i++) ramq.push_back($urandom);
  endtask

  // One clock: drive inputs after the edge, compare against the model, advance the model.
  task automatic applyStimulus(input bit stall, input bit pop, input bit srst);
    bit e, ev, v2, qp, rp;
    int credit;
    logic [31:0] w;
    @(posedge clk);
    #2;
    e = stall || (ramq.size() == 0);
    sync_rst_n = srst;
    emp[cur]   = e;
    popi[cur]  = pop;
    rdata[cur] = slot[cyc % 8];
    #2;
    ev     = avail.size() > 0;
    v2     = avail.size() > 1;
    qp     = pop && ev;
    credit = avail.size() + infl_w.size();
    rp     = !e && srst && ((credit < skid) || qp);
    checkOutput("ram_pop", {31'd0, rpop[cur]}, {31'd0, rp});
    checkOutput("ft_valid", {31'd0, fv[cur]}, {31'd0, ev});
    checkOutput("ft_valid2", {31'd0, fv2[cur]}, {31'd0, v2});
    checkOutput("ft_cnt", {29'd0, cnt3[cur]}, avail.size());
    if (ev) checkOutput("ft_data", fd[cur], avail[0]);
    if (v2) checkOutput("ft_data2", fd2[cur], avail[1]);
    w = $urandom;
    if (rp) begin
      w = ramq.pop_front();
      infl_w.push_back(w);
      infl_t.push_back(cyc + lat);
    end
    slot[(cyc + lat) % 8] = w;
    if (!srst) begin
      avail.delete();
      infl_w.delete();
      infl_t.delete();
    end else begin
      if (qp) void'(avail.pop_front());
      if (infl_t.size() > 0 && infl_t[0] == cyc) begin
        avail.push_back(infl_w.pop_front());
        void'(infl_t.pop_front());
      end
    end
    cyc++;
  endtask

  task automatic runConfig(input int k);
    int guard;
    cur     = k;
    lat     = (k == 0) ? 2 : (k == 1) ? 1 : 4;
    lessrst = (k == 1);
    skid    = lat + 1;
    ramq.delete();
    avail.delete();
    infl_w.delete();
    infl_t.delete();
    for (int i = 0; i < 8; i++) slot[i] = $urandom;
    cyc = 0;

    // Async reset with a pop request and a non-empty RAM must still be quiet.
    @(negedge clk);
    sync_rst_n = 1'b0;
    emp[k]  = 1'b0;
    popi[k] = 1'b1;
    rst_n   = 1'b0;
    #1;
    checkOutput("rst_ram_pop", {31'd0, rpop[k]}, 32'd0);
    checkOutput("rst_valid", {31'd0, fv[k]}, 32'd0);
    checkOutput("rst_valid2", {31'd0, fv2[k]}, 32'd0);
    checkOutput("rst_cnt", {29'd0, cnt3[k]}, 32'd0);
    if (!lessrst) begin
      checkOutput("rst_data", fd[k], 32'd0);
      checkOutput("rst_data2", fd2[k], 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);

    pushWords(3);
    repeat (lat + 5) applyStimulus(1'b0, 1'b0, 1'b1);
    pushWords(8);
    repeat (lat + 4) applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      repeat (lat) applyStimulus(1'b0, 1'b0, 1'b1);
    end

    pushWords(16);
    repeat (30) applyStimulus(1'b0, 1'b1, 1'b1);
    guard = 0;
    while ((ramq.size() + avail.size() + infl_w.size()) > 0 && guard < 100) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      guard++;
    end
    repeat (6) applyStimulus(1'b0, 1'b1, 1'b1);

    pushWords(6);
    repeat (lat + 1) applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (12) applyStimulus(1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 10000; i++) begin
      if (($urandom % 3) == 0) pushWords(1);
      applyStimulus(bit'($urandom % 2), bit'($urandom % 2), ($urandom % 100) != 0);
    end

    @(posedge clk);
    #2;
    emp[k]     = 1'b1;
    popi[k]    = 1'b0;
    sync_rst_n = 1'b0;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b1;
    sync_rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      emp[k]   = 1'b1;
      popi[k]  = 1'b0;
      rdata[k] = '0;
    end
    for (int k = 0; k < 3; k++) begin
      $display("[TB] running configuration %0d", k);
      runConfig(k);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
